// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// ULA operations, opcodes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SUB = 4'b0001;
    localparam logic [3:0] ULA_AND = 4'b0010;
    localparam logic [3:0] ULA_OR  = 4'b0011;
    localparam logic [3:0] ULA_SLT = 4'b0101;
    localparam logic [3:0] ULA_XOR = 4'b0111;
    localparam logic [3:0] ULA_SRL = 4'b1000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ULA    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [1:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ula_decoder.sv
// Combinational op/funct3/funct7 to ULA operation decoder with a legality flag
// for R-type, I-type ALU and branch instructions.
module ula_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] ula_control,
    output logic       legal
);

    always_comb begin
        ula_control = ULA_ADD;
        legal       = 1'b0;
        case (op)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            ula_control = ULA_ADD;
                            legal       = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            ula_control = ULA_SUB;
                            legal       = 1'b1;
                        end
                    end
                    3'b111: begin ula_control = ULA_AND; legal = 1'b1; end
                    3'b110: begin ula_control = ULA_OR;  legal = 1'b1; end
                    3'b010: begin ula_control = ULA_SLT; legal = 1'b1; end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            ula_control = ULA_SRL;
                            legal       = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin ula_control = ULA_ADD; legal = 1'b1; end
                    3'b110: begin ula_control = ULA_OR;  legal = 1'b1; end
                    3'b100: begin ula_control = ULA_XOR; legal = 1'b1; end
                    3'b111: begin ula_control = ULA_AND; legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_BRANCH: begin
                // Comparison is always a subtract; only beq/bne are supported.
                ula_control = ULA_SUB;
                legal       = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback with memory wait handshake and illegal-instruction trap.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int ULACTRL_W   = 4,
    parameter int MEM_WAIT    = 1,
    parameter int TRAP_STICKY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           ula_src_a,
    output logic [1:0]           ula_src_b,
    output logic [1:0]           imm_src,
    output logic [ULACTRL_W-1:0] ula_control,
    output logic                 illegal,
    output logic                 instr_done
);

    state_t     state_reg;
    state_t     state_next;
    logic       ready;
    logic [3:0] dec_ula;
    logic       dec_legal;
    logic [3:0] ula_op;

    assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    ula_decoder u_ula_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .ula_control (dec_ula),
        .legal       (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        ula_src_a  = SRCA_PC;
        ula_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        ula_op     = ULA_ADD;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed and latched in the same cycle the IR loads.
                ula_src_b  = SRCB_FOUR;
                result_src = RES_ULA;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                ula_src_a = SRCA_OLDPC;
                ula_src_b = SRCB_IMM;
                imm_src   = imm_for_op(op);
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ula_src_a  = SRCA_RS1;
                ula_src_b  = SRCB_IMM;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = ready;
                if (ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ula_src_a  = SRCA_RS1;
                ula_src_b  = SRCB_RS2;
                ula_op     = dec_ula;
                state_next = dec_legal ? S_ALUWB : S_TRAP;
            end
            S_EXECI: begin
                ula_src_a  = SRCA_RS1;
                ula_src_b  = SRCB_IMM;
                ula_op     = dec_ula;
                state_next = dec_legal ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ula_src_a = SRCA_RS1;
                ula_src_b = SRCB_RS2;
                ula_op    = dec_ula;
                if (dec_legal) begin
                    pc_write   = ((funct3 == 3'b000) && zero) ||
                                 ((funct3 == 3'b001) && !zero);
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_JAL: begin
                // Target from DECODE sits in ALUOut; this cycle forms the link value.
                ula_src_a  = SRCA_OLDPC;
                ula_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = (TRAP_STICKY != 0) ? S_TRAP : S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ula_control = ULACTRL_W'(ula_op);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized bench for riscv_multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle control vectors.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;

    localparam logic [4:0] U_ADD = 5'd0;
    localparam logic [4:0] U_SUB = 5'd1;
    localparam logic [4:0] U_AND = 5'd2;
    localparam logic [4:0] U_OR  = 5'd3;
    localparam logic [4:0] U_SLT = 5'd5;
    localparam logic [4:0] U_XOR = 5'd7;
    localparam logic [4:0] U_SRL = 5'd8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a: MEM_WAIT=1, TRAP_STICKY=1, ULACTRL_W=4
    logic       rst_n_a = 1'b0, zero_a = 1'b0, mr_a = 1'b0;
    logic [6:0] op_a = '0, f7_a = '0;
    logic [2:0] f3_a = '0;
    logic       pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a, done_a;
    logic [1:0] rs_a, sa_a, sb_a, imm_a;
    logic [3:0] ula_a;

    // DUT b: MEM_WAIT=0, TRAP_STICKY=0, ULACTRL_W=5
    logic       rst_n_b = 1'b0, zero_b = 1'b0, mr_b = 1'b0;
    logic [6:0] op_b = '0, f7_b = '0;
    logic [2:0] f3_b = '0;
    logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b, done_b;
    logic [1:0] rs_b, sa_b, sb_b, imm_b;
    logic [4:0] ula_b;

    riscv_multicycle_ctrl #(.ULACTRL_W(4), .MEM_WAIT(1), .TRAP_STICKY(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .op(op_a), .funct3(f3_a), .funct7(f7_a),
        .zero(zero_a), .mem_ready(mr_a), .pc_write(pcw_a), .adr_src(adr_a),
        .mem_write(mw_a), .ir_write(irw_a), .reg_write(rw_a), .result_src(rs_a),
        .ula_src_a(sa_a), .ula_src_b(sb_a), .imm_src(imm_a), .ula_control(ula_a),
        .illegal(ill_a), .instr_done(done_a)
    );

    riscv_multicycle_ctrl #(.ULACTRL_W(5), .MEM_WAIT(0), .TRAP_STICKY(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .op(op_b), .funct3(f3_b), .funct7(f7_b),
        .zero(zero_b), .mem_ready(mr_b), .pc_write(pcw_b), .adr_src(adr_b),
        .mem_write(mw_b), .ir_write(irw_b), .reg_write(rw_b), .result_src(rs_b),
        .ula_src_a(sa_b), .ula_src_b(sb_b), .imm_src(imm_b), .ula_control(ula_b),
        .illegal(ill_b), .instr_done(done_b)
    );

    typedef struct {
        bit         rst;
        bit         chk;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         zr;
        bit         mr;
        logic [19:0] exp;
        string      tag;
        string      note;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    txn = 0;
    int    cyc = 0;
    bit    cur_mw;
    bit    cur_sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, imm_src, ula, illegal, done}
    function automatic logic [19:0] vec(input bit pcw, input bit adr, input bit mw, input bit irw,
                                        input bit rw, input logic [1:0] rs, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [1:0] imm,
                                        input logic [4:0] ula, input bit ill, input bit done);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ula, ill, done};
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == ST) return 2'b01;
        if (op == BR) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [4:0] ref_ula(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, output bit legal);
        legal = 1'b0;
        if (op == RT) begin
            if (f3 == 3'd0 && f7 == 7'h00) begin legal = 1'b1; return U_ADD; end
            if (f3 == 3'd0 && f7 == 7'h20) begin legal = 1'b1; return U_SUB; end
            if (f3 == 3'd7) begin legal = 1'b1; return U_AND; end
            if (f3 == 3'd6) begin legal = 1'b1; return U_OR; end
            if (f3 == 3'd2) begin legal = 1'b1; return U_SLT; end
            if (f3 == 3'd5 && f7 == 7'h00) begin legal = 1'b1; return U_SRL; end
        end else if (op == IT) begin
            if (f3 == 3'd0) begin legal = 1'b1; return U_ADD; end
            if (f3 == 3'd6) begin legal = 1'b1; return U_OR; end
            if (f3 == 3'd4) begin legal = 1'b1; return U_XOR; end
            if (f3 == 3'd7) begin legal = 1'b1; return U_AND; end
        end else if (op == BR) begin
            legal = (f3 == 3'd0) || (f3 == 3'd1);
            return U_SUB;
        end
        return U_ADD;
    endfunction

    task automatic push(input bit rst, input bit chk, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input bit zr, input bit mr,
                        input logic [19:0] exp, input string tag);
        item_t it;
        it.rst = rst; it.chk = chk; it.op = op; it.f3 = f3; it.f7 = f7;
        it.zr = zr; it.mr = mr; it.exp = exp; it.tag = tag; it.note = "";
        q.push_back(it);
    endtask

    task automatic add_reset();
        push(1'b1, 1'b0, '0, '0, '0, rbit(), rbit(), '0, "reset");
        push(1'b0, 1'b1, '0, '0, '0, rbit(), rbit(), '0, "idle");
    endtask

    task automatic add_trap(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int n;
        n = cur_sticky ? 10 + int'($urandom_range(0, 3)) : 1;
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                 vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 1, 0), "trap");
        if (cur_sticky) add_reset();
    endtask

    // Memory-stalled step: with waits honoured, wc not-ready cycles precede the ready one.
    task automatic add_mem_step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input int wc, input logic [19:0] v_wait, input logic [19:0] v_go,
                                input string tag);
        if (cur_mw)
            for (int i = 0; i < wc; i++)
                push(1'b0, 1'b1, op, f3, f7, rbit(), 1'b0, v_wait, {tag, "_wait"});
        push(1'b0, 1'b1, op, f3, f7, rbit(), cur_mw ? 1'b1 : rbit(), v_go, tag);
    endtask

    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input bit zr, input int wf, input int wm);
        bit         legal;
        bit         taken;
        logic [4:0] u;
        txn++;
        add_mem_step(op, f3, f7, wf,
                     vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, U_ADD, 0, 0),
                     vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, U_ADD, 0, 0), "fetch");
        push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
             vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ref_imm(op), U_ADD, 0, 0), "decode");
        u = ref_ula(op, f3, f7, legal);
        if (op == LD || op == ST) begin
            push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                 vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, U_ADD, 0, 0), "memadr");
            if (op == LD) begin
                add_mem_step(op, f3, f7, wm,
                             vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 0),
                             vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 0), "memread");
                push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                     vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, U_ADD, 0, 1), "memwb");
            end else begin
                add_mem_step(op, f3, f7, wm,
                             vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 0),
                             vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 1), "memwrite");
            end
        end else if (op == RT || op == IT) begin
            push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                 vec(0, 0, 0, 0, 0, 2'b00, 2'b10, (op == IT) ? 2'b01 : 2'b00, 2'b00, u, 0, 0),
                 (op == IT) ? "execi" : "execr");
            if (legal)
                push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                     vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 1), "aluwb");
            else
                add_trap(op, f3, f7);
        end else if (op == BR) begin
            taken = legal && ((f3 == 3'd0 && zr) || (f3 == 3'd1 && !zr));
            push(1'b0, 1'b1, op, f3, f7, zr, rbit(),
                 vec(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, U_SUB, 0, legal), "branch");
            if (!legal) add_trap(op, f3, f7);
        end else if (op == JL) begin
            push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                 vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, U_ADD, 0, 0), "jal");
            push(1'b0, 1'b1, op, f3, f7, rbit(), rbit(),
                 vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 1), "aluwb");
        end else begin
            add_trap(op, f3, f7);
        end
        q[q.size() - 1].note = $sformatf("txn %0d: op=%b f3=%b f7=%b zero=%0d wf=%0d wm=%0d",
                                         txn, op, f3, f7, zr, wf, wm);
    endtask

    task automatic add_random(input int n);
        logic [6:0] op;
        logic [6:0] f7;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: op = LD;
                1: op = ST;
                2, 3: op = RT;
                4: op = IT;
                5: op = BR;
                6: op = JL;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1: f7 = 7'h00;
                2: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            add_instr(op, 3'($urandom), f7, rbit(), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)));
        end
    endtask

    task automatic run(input bit sel);
        item_t       it;
        logic [19:0] got;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk);
            #1;
            if (!sel) begin
                rst_n_a = !it.rst; op_a = it.op; f3_a = it.f3; f7_a = it.f7;
                zero_a = it.zr; mr_a = it.mr;
            end else begin
                rst_n_b = !it.rst; op_b = it.op; f3_b = it.f3; f7_b = it.f7;
                zero_b = it.zr; mr_b = it.mr;
            end
            #1;
            if (it.chk) begin
                if (!sel)
                    got = {pcw_a, adr_a, mw_a, irw_a, rw_a, rs_a, sa_a, sb_a, imm_a,
                           1'b0, ula_a, ill_a, done_a};
                else
                    got = {pcw_b, adr_b, mw_b, irw_b, rw_b, rs_b, sa_b, sb_b, imm_b,
                           ula_b, ill_b, done_b};
                check($sformatf("%s_%s@%0d", sel ? "b" : "a", it.tag, cyc), got, it.exp);
            end
            if (it.note != "") $display("%s %s", sel ? "b" : "a", it.note);
            cyc++;
        end
    endtask

    initial begin
        // Waits honoured, sticky trap.
        cur_mw = 1'b1;
        cur_sticky = 1'b1;
        add_reset();
        add_instr(RT, 3'b000, 7'h00, 1'b0, 0, 0);
        add_instr(LD, 3'b010, 7'h00, 1'b0, 2, 3);
        add_instr(BR, 3'b001, 7'h00, 1'b0, 0, 0);
        add_instr(BR, 3'b000, 7'h00, 1'b0, 0, 0);
        add_instr(BR, 3'b000, 7'h00, 1'b1, 0, 0);
        add_instr(JL, 3'b000, 7'h00, 1'b0, 0, 0);
        add_instr(ST, 3'b010, 7'h00, 1'b0, 1, 2);
        // Reset while a load waits in MEMREAD.
        push(1'b0, 1'b1, LD, 3'b010, 7'h00, 1'b0, 1'b1,
             vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, U_ADD, 0, 0), "fetch");
        push(1'b0, 1'b1, LD, 3'b010, 7'h00, 1'b0, 1'b0,
             vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, U_ADD, 0, 0), "decode");
        push(1'b0, 1'b1, LD, 3'b010, 7'h00, 1'b0, 1'b0,
             vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, U_ADD, 0, 0), "memadr");
        push(1'b0, 1'b1, LD, 3'b010, 7'h00, 1'b0, 1'b0,
             vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, U_ADD, 0, 0), "memread_wait");
        add_reset();
        add_instr(IT, 3'b100, 7'h00, 1'b0, 0, 0);
        add_random(60);
        add_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0);
        add_instr(RT, 3'b000, 7'h20, 1'b0, 0, 0);
        run(1'b0);

        // Waits ignored, one-cycle trap.
        cur_mw = 1'b0;
        cur_sticky = 1'b0;
        add_reset();
        add_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0);
        add_instr(RT, 3'b101, 7'h00, 1'b0, 0, 0);
        add_instr(RT, 3'b001, 7'h00, 1'b0, 0, 0);
        add_instr(BR, 3'b100, 7'h00, 1'b0, 0, 0);
        add_instr(LD, 3'b010, 7'h00, 1'b0, 0, 0);
        add_random(40);
        run(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multicycle RISC-V control unit. It replaces the single-cycle combinational decoder with a registered Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It sits beside the shared-memory multicycle datapath and drives its PC, IR, ULA (ALU), register-file and memory-enable controls. It adds a memory wait handshake, branch resolution, illegal-instruction trapping and an instruction-retired pulse.

## Interface
- `ULACTRL_W`, default 4: width of `ula_control`; must be ≥4, upper bits zero.
- `MEM_WAIT`, default 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as constant 1.
- `TRAP_STICKY`, default 1: 1 = illegal opcode parks the FSM in TRAP until reset; 0 = one TRAP cycle, then FETCH.
- `clk  in  1` clock; single clock domain.
- `rst_n  in  1` reset, synchronous, active-low.
- `op  in  7` instruction opcode from IR.
- `funct3  in  3` IR[14:12].
- `funct7  in  7` IR[31:25].
- `zero  in  1` ULA zero flag.
- `mem_ready  in  1` memory access completes this cycle.
- `pc_write  out  1` PC load enable (unconditional or taken branch).
- `adr_src  out  1` 0 = PC, 1 = ALUOut drives the memory address.
- `mem_write  out  1` memory write strobe.
- `ir_write  out  1` IR and OldPC load.
- `reg_write  out  1` register-file write.
- `result_src  out  2` 00 ALUOut, 01 Data, 10 ULA result.
- `ula_src_a  out  2` 00 PC, 01 OldPC, 10 rs1.
- `ula_src_b  out  2` 00 rs2, 01 ImmExt, 10 constant 4.
- `imm_src  out  2` 00 I, 01 S, 10 B, 11 J.
- `ula_control  out  ULACTRL_W` ULA operation.
- `illegal  out  1` unsupported instruction detected.
- `instr_done  out  1` one-cycle pulse in the final state of each instruction.

## Operation
- ULA encodings (shared package): ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101, XOR 0111, SRL 1000.
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: adr_src=0, ula_src_a=00, ula_src_b=10, ADD, result_src=10. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE: ula_src_a=01, ula_src_b=01, ADD (branch/jump target). imm_src follows the opcode: 0010011/0000011 I, 0100011 S, 1100011 B, 1101111 J. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP
- MEMADR: ula_src_a=10, ula_src_b=01, ADD. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src=1. Waits for `mem_ready`, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until `mem_ready`; instr_done pulses on that same cycle. Next FETCH.
- EXECR: ula_src_a=10, ula_src_b=00. Operation by funct3/funct7:
  - 000/0000000 ADD; 000/0100000 SUB
  - 111 AND; 110 OR; 010 SLT; 101/0000000 SRL
  - any other combination → TRAP
- EXECI: ula_src_a=10, ula_src_b=01. funct3 000 ADD, 110 OR, 100 XOR, 111 AND; any other funct3 → TRAP.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next FETCH.
- BRANCH: ula_src_a=10, ula_src_b=00, SUB, result_src=00, instr_done=1. `pc_write` = (funct3==000 & zero) | (funct3==001 & ~zero). Any other funct3 → TRAP instead. Next FETCH.
- JAL: ula_src_a=01, ula_src_b=10, ADD, result_src=00, pc_write=1. Next ALUWB (writes rd=OldPC+4).
- TRAP: illegal=1, all write enables 0. With TRAP_STICKY=1 stays in TRAP; with 0 goes to FETCH.

## Timing
- State register updates on the rising `clk` edge. All outputs are combinational functions of the state plus `op`/`funct3`/`funct7`/`zero`/`mem_ready`. No output registers.
- `rst_n`=0 at an edge forces IDLE, including mid-instruction or mid-wait. A partial instruction is abandoned with no write.
- Zero-wait cycle counts, fetch through done: R/I 4, load 5, store 4, branch 3, jal 4.
- With MEM_WAIT=1, each `mem_ready`=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE. Outputs are held stable during the wait.
- TRAP is detected one cycle after the instruction leaves DECODE, or in DECODE's next-state for a bad opcode. No register or memory write occurs for an illegal instruction.

## Structure
- Package `riscv_ctrl_pkg`: state enum, ULA op constants, opcode constants, ImmSrc/ResultSrc/ULASrc encodings.
- One sub-module: `ula_decoder`, a combinational op/funct3/funct7 → ula_control + legal flag decoder, used in EXECR/EXECI/BRANCH.

## Test plan
- Reset mid-MEMREAD → IDLE next cycle with all outputs 0, then FETCH.
- `add` (op 0110011, f3 000, f7 0) with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; ula_control 0000; reg_write high only in ALUWB; instr_done on cycle 4.
- `lw` with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → total 10 cycles; ir_write high exactly once; result_src=01 in MEMWB.
- `bne` with zero=0 → pc_write=1 in BRANCH. `beq` with zero=0 → pc_write=0. Both take 3 cycles.
- `jal` → pc_write in FETCH and JAL; reg_write in ALUWB with result_src 00.
- op 1111111 → TRAP, illegal=1 held for 10+ cycles (TRAP_STICKY=1). With TRAP_STICKY=0, FETCH follows after one cycle. No reg_write or mem_write in either case.
